// File: rtl/inst_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Address split for the default geometry: | tag | index | word | byte |
  localparam int WORD_CNT_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int OFFSET_W   = WORD_CNT_W + 2;
  localparam int INDEX_W    = $clog2(DEF_LINES);
  localparam int TAG_W      = DEF_DATA_WIDTH - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESPOND
  } state_e;

endpackage

// File: rtl/inst_cache_data_array.sv
// Cache data storage: one synchronous write port, one asynchronous read port.
module inst_cache_data_array #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              we_i,
  input  logic [$clog2(LINES)-1:0]          wline_i,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] wword_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic [$clog2(LINES)-1:0]          rline_i,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] rword_i,
  output logic [DATA_WIDTH-1:0]             rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [LINES][WORDS_PER_LINE];

  // NOTE: storage arrays carry no reset; per-line valid bits decide whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wline_i][wword_i] <= wdata_i;
  end

  assign rdata_o = mem_q[rline_i][rword_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with whole-line, word-by-word refill.
// Define INST_CACHE_PERF_EN to add hit_count/miss_count performance counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  inst_flush,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef INST_CACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int CNT_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS = CNT_BITS + 2;
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = DATA_WIDTH - OFF_BITS - IDX_BITS;
  localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(WORDS_PER_LINE - 1);

  state_e                   state_q;
  logic [DATA_WIDTH-1:2]    addr_q;
  logic [CNT_BITS-1:0]      cnt_q;
  logic                     flush_q;
  logic [LINES-1:0]         valid_q;
  logic [TAG_BITS-1:0]      tag_q [LINES];
  logic                     mem_req_q;
  logic [DATA_WIDTH-1:0]    mem_addr_q;

  logic [TAG_BITS-1:0]      req_tag;
  logic [IDX_BITS-1:0]      req_idx;
  logic [CNT_BITS-1:0]      req_word;
  logic [CNT_BITS-1:0]      cnt_d;
  logic                     hit;
  logic                     word_we;
  logic                     refill_done;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     unused_byte_bits;

  assign unused_byte_bits = ^inst_addr[1:0];

  assign req_tag  = addr_q[DATA_WIDTH-1 -: TAG_BITS];
  assign req_idx  = addr_q[OFF_BITS +: IDX_BITS];
  assign req_word = addr_q[2 +: CNT_BITS];
  assign cnt_d    = cnt_q + CNT_BITS'(1);

  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign word_we     = (state_q == REFILL) && mem_valid;
  assign refill_done = word_we && (cnt_q == LAST_WORD);

  inst_cache_data_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LINES         (LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_data (
    .clk    (clk),
    .we_i   (word_we),
    .wline_i(req_idx),
    .wword_i(cnt_q),
    .wdata_i(mem_rdata),
    .rline_i(req_idx),
    .rword_i(req_word),
    .rdata_o(rd_word)
  );

  // Responses come straight out of LOOKUP/RESPOND so a hit retires in the cycle after acceptance.
  assign inst_valid = ((state_q == LOOKUP) && hit) || (state_q == RESPOND);
  assign inst_data  = inst_valid ? rd_word : '0;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

  always_ff @(posedge clk) begin
    if (refill_done) tag_q[req_idx] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_q <= 1'b0;
          if (inst_req) begin
            addr_q  <= inst_addr[DATA_WIDTH-1:2];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state_q <= IDLE;
          end else begin
            state_q    <= REFILL;
            cnt_q      <= '0;
            flush_q    <= inst_flush;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {req_tag, req_idx, {CNT_BITS{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (inst_flush) flush_q <= 1'b1;
          if (mem_valid) begin
            cnt_q      <= cnt_d;
            mem_addr_q <= {req_tag, req_idx, cnt_d, 2'b00};
            if (cnt_q == LAST_WORD) begin
              mem_req_q <= 1'b0;
              state_q   <= RESPOND;
            end
          end
        end
        RESPOND: begin
          // A flush seen anywhere in this refill leaves the line invalid; the data still goes out.
          if (!flush_q && !inst_flush) valid_q[req_idx] <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (inst_flush) valid_q <= '0;
    end
  end

`ifdef INST_CACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: directed requests push expected responses and refill addresses,
// a negedge monitor pops and compares them whenever the DUT presents inst_valid or a memory handshake.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        inst_flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic mem_en = 1'b1;
  logic late_pulse = 1'b0;

  logic [31:0] exp_resp_q[$];
  logic [31:0] exp_mem_q[$];

  inst_cache dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_valid(inst_valid),
    .inst_data (inst_data),
    .inst_flush(inst_flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
`ifdef INST_CACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

`ifndef INST_CACHE_PERF_EN
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: every word reads back as its own address.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_valid = ((mem_req === 1'b1) && mem_en) || late_pulse;
      mem_rdata = mem_valid ? mem_addr : 32'h0;
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents something.
  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      if (exp_resp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got 0x%08h, expected no response", inst_data);
      end else begin
        check("resp_data", inst_data, exp_resp_q.pop_front());
      end
    end
    if (mem_req === 1'b1 && mem_valid === 1'b1) begin
      if (exp_mem_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_mem: got 0x%08h, expected no refill", mem_addr);
      end else begin
        check("mem_addr", mem_addr, exp_mem_q.pop_front());
      end
    end
  end

  // One fetch: exp_lat is the cycle (after acceptance) in which inst_valid must appear;
  // flush_at raises inst_flush for exactly that cycle.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] exp_data,
                        input int exp_lat, input int flush_at);
    int n;
    logic [31:0] base;
    n = 0;
    base = {exp_data[31:4], 4'h0};
    exp_resp_q.push_back(exp_data);
    if (exp_lat != 1)
      for (int w = 0; w < 4; w++) exp_mem_q.push_back(base + 32'(w * 4));
    inst_addr = addr;
    inst_req  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      inst_flush = (n == flush_at);
    end while (inst_valid !== 1'b1 && n < 20);
    if (exp_lat == 1) begin
      exp_hits++;
      check("hit_no_mem_req", 32'(mem_req), 32'h0);
    end else begin
      exp_misses++;
    end
    inst_req = 1'b0;
    check("latency", 32'(n), 32'(exp_lat));
    @(posedge clk);
    #1;
    inst_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = '0;
    inst_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, then hit in the same line.
    do_req(32'h100, 32'h100, 6, 0);
    do_req(32'h108, 32'h108, 1, 0);

    // Conflict on index 0.
    do_req(32'h500, 32'h500, 6, 0);
    do_req(32'h100, 32'h100, 6, 0);

    // Idle flush pulse invalidates the warm line.
    inst_flush = 1'b1;
    @(posedge clk);
    #1;
    inst_flush = 1'b0;
    do_req(32'h104, 32'h104, 6, 0);

    // Flush in a LOOKUP hit still returns data (byte offset ignored), then the line is gone.
    do_req(32'h10B, 32'h108, 1, 1);
    do_req(32'h10C, 32'h10C, 6, 0);

    // Flush while refilling word 2: response delivered, line not validated.
    do_req(32'h200, 32'h200, 6, 4);
    do_req(32'h200, 32'h200, 6, 0);

    // Reset after the second refill word of 0x300.
    exp_mem_q.push_back(32'h300);
    exp_mem_q.push_back(32'h304);
    inst_addr = 32'h300;
    inst_req  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_mem_addr", mem_addr, 32'h308);
    rst      = 1'b0;
    mem_en   = 1'b0;
    inst_req = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(posedge clk);
    #1;
    check("reset_mem_req", 32'(mem_req), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(inst_cache_pkg::IDLE));
    check("reset_inst_valid", 32'(inst_valid), 32'h0);
    rst        = 1'b1;
    mem_en     = 1'b1;
    late_pulse = 1'b1;
    @(posedge clk);
    #1;
    late_pulse = 1'b0;
    check("late_valid_mem_req", 32'(mem_req), 32'h0);
    check("late_valid_state", 32'(dut.state_q), 32'(inst_cache_pkg::IDLE));
    do_req(32'h300, 32'h300, 6, 0);

    // Mixed hits and misses for the performance counters: 3 misses, 5 hits since reset.
    do_req(32'h30E, 32'h30C, 1, 0);
    do_req(32'h304, 32'h304, 1, 0);
    do_req(32'h110, 32'h110, 6, 0);
    do_req(32'h114, 32'h114, 1, 0);
    do_req(32'h118, 32'h118, 1, 0);
    do_req(32'h300, 32'h300, 1, 0);
    do_req(32'h2F0, 32'h2F0, 6, 0);

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'h0);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'h0);
`ifdef INST_CACHE_PERF_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
    check("hit_count_abs", hit_count, 32'd5);
    check("miss_count_abs", miss_count, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
